// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg
// Shared AXI4-Lite definitions used by the read-side and write-side slave
// blocks: the response code type, the response code constants and a helper
// that returns how many low address bits must be zero for an aligned access.
// No ports (package).
package axi4lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // Number of byte-offset bits inside one data word (2 for 32-bit, 3 for 64-bit).
  function automatic int addr_lsb_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi4lite_resp_fifo.sv
// axi4lite_resp_fifo
// Synchronous response FIFO, DEPTH entries of WIDTH bits, with a
// combinational view of the head entry.  A push is accepted while full as
// long as a pop happens in the same cycle.
// Ports:
//   aclk, aresetn         clock, asynchronous active-low reset
//   push, push_data       write strobe and entry
//   pop                   remove head entry (ignored when empty)
//   head_data             oldest entry
//   full, empty           occupancy flags
module axi4lite_resp_fifo
  import axi4lite_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi4lite_read_slave_pipe.sv
// axi4lite_read_slave_pipe
// Pipelined AXI4-Lite read slave.  Each accepted AR beat is classified
// (misaligned -> SLVERR, unmapped -> DECERR, else OKAY) into a one-entry
// request stage.  OKAY entries are forwarded to the backend; error entries
// skip it.  Completed entries queue in a response FIFO whose head drives the
// R channel, so responses come back in acceptance order.
// Optional feature macro: AXI4LITE_RD_PROT_CHECK_EN -- when defined,
// unprivileged reads (arprot[0]=0) are answered with SLVERR.
// Ports:
//   aclk, aresetn                     clock, asynchronous active-low reset
//   arvalid/arready/araddr/arprot     AXI4-Lite read address channel
//   rvalid/rready/rdata/rresp         AXI4-Lite read data channel
//   req_valid/req_ready/req_addr      backend read request
//   rsp_data                          backend data, valid on req handshake
module axi4lite_read_slave_pipe
  import axi4lite_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              ADDR_W     = 32,
  parameter int              DEPTH      = 4,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 'h1000
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [2:0]        arprot,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] rsp_data
);

  localparam int LSB   = addr_lsb_bits(DATA_W);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = DATA_W + 2;

  logic              init_done;
  logic [CNT_W-1:0]  outstanding;
  logic              stage_valid;
  logic [ADDR_W-1:0] stage_addr;
  resp_t             stage_resp;
  resp_t             capture_resp;
  logic              stage_okay;
  logic              fifo_room;
  logic              stage_retire;
  logic              ar_hs;
  logic              r_hs;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  push_entry;
  logic [ENT_W-1:0]  head_entry;

  // Later assignments override earlier ones, so the last check listed has
  // the highest priority: misalignment, then privilege, then address range.
  always_comb begin
    capture_resp = RESP_OKAY;
    if (araddr >= ADDR_LIMIT) capture_resp = RESP_DECERR;
`ifdef AXI4LITE_RD_PROT_CHECK_EN
    if (!arprot[0]) capture_resp = RESP_SLVERR;
`endif
    if (araddr[LSB-1:0] != '0) capture_resp = RESP_SLVERR;
  end

`ifndef AXI4LITE_RD_PROT_CHECK_EN
  logic unused_prot;
  assign unused_prot = ^arprot;
`endif

  // Outstanding <= DEPTH guarantees room whenever the stage is occupied; the
  // room term only keeps the FIFO safe should that invariant ever break.
  assign fifo_room    = ~fifo_full | r_hs;
  assign stage_okay   = (stage_resp == RESP_OKAY);
  assign stage_retire = stage_valid & fifo_room & (~stage_okay | req_ready);
  assign req_valid    = stage_valid & stage_okay & fifo_room;
  assign req_addr     = stage_addr;

  // init_done holds arready low until the first edge after reset release.
  assign arready = init_done & (outstanding < CNT_W'(DEPTH)) &
                   (~stage_valid | stage_retire);
  assign ar_hs   = arvalid & arready;
  assign r_hs    = rvalid & rready;

  assign push_entry = {(stage_okay ? rsp_data : {DATA_W{1'b0}}), stage_resp};

  assign rvalid = ~fifo_empty;
  assign rdata  = rvalid ? head_entry[ENT_W-1:2] : '0;
  assign rresp  = rvalid ? head_entry[1:0] : RESP_OKAY;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) init_done <= 1'b0;
    else          init_done <= 1'b1;
  end

  // A new capture may overwrite the stage only in the cycle it retires.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_resp  <= RESP_OKAY;
    end else if (ar_hs) begin
      stage_valid <= 1'b1;
      stage_addr  <= araddr;
      stage_resp  <= capture_resp;
    end else if (stage_retire) begin
      stage_valid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outstanding <= '0;
    end else begin
      case ({ar_hs, r_hs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  axi4lite_resp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (stage_retire),
    .push_data (push_entry),
    .pop       (r_hs),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
